// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared definitions for the ROM fetch controller and the benches that drive it.
// Holds the FSM state encoding and the default bus widths.
package rom_fetch_ctrl_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   // Instr/oprnd are the two halves of a ROM word.
   function automatic int half_width(input int data_w);
      return data_w / 2;
   endfunction

endpackage : rom_fetch_ctrl_pkg

// File: rtl/rom_fetch_ctrl_if.sv
// ROM bus and consumer handshake of the fetch controller.
// master = controller side, slave = ROM model plus consumer side.
interface rom_fetch_ctrl_if
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [ADDR_W-1:0]   rom_addr;
   logic [DATA_W-1:0]   rom_data;
   logic [DATA_W/2-1:0] instr;
   logic [DATA_W/2-1:0] oprnd;
   logic                valid;
   logic                ready;

   modport master (
      output rom_addr,
      input  rom_data,
      output instr,
      output oprnd,
      output valid,
      input  ready
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  instr,
      input  oprnd,
      input  valid,
      output ready
   );

endinterface : rom_fetch_ctrl_if

// File: rtl/rom_fetch_ctrl_prog_counter.sv
// Program counter: synchronous load, modulo-2^ADDR_W increment and a one-cycle
// wrap pulse when the increment rolls over from all-ones to zero.
module prog_counter
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc,
   output logic              wrap
);

   logic [ADDR_W-1:0] pc_q;
   logic              wrap_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= '0;
         wrap_q <= 1'b0;
      end else if (ld) begin
         pc_q   <= ld_addr;
         wrap_q <= 1'b0;
      end else if (inc) begin
         pc_q   <= pc_q + ADDR_W'(1);
         wrap_q <= &pc_q;
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign pc   = pc_q;
   assign wrap = wrap_q;

endmodule : prog_counter

// File: rtl/rom_fetch_ctrl.sv
// Fetch controller for an external combinational ROM: IDLE/FETCH/HOLD FSM,
// a fetch register split into instr/oprnd, and a valid/ready consumer handshake.
module rom_fetch_ctrl
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              wrap,
   rom_fetch_ctrl_if.master  bus
);

   localparam int HALF_W = DATA_W / 2;

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic              capture;
   logic              inc;
   logic [DATA_W-1:0] word_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ld overrides whatever the state would have done, including a pending capture.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en) state_d = FETCH;
         end
         FETCH: begin
            capture = 1'b1;
            inc     = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.ready) state_d = en ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (ld) begin
         state_d = IDLE;
         capture = 1'b0;
         inc     = 1'b0;
      end
   end

   prog_counter #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .ld      (ld),
      .ld_addr (ld_addr),
      .inc     (inc),
      .pc      (pc),
      .wrap    (wrap)
   );

   // fetch register stage: ROM word captured at the end of FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         word_p1 <= '0;
      end else if (capture) begin
         word_p1 <= bus.rom_data;
      end
   end

   assign bus.rom_addr = pc;
   assign bus.instr    = word_p1[DATA_W-1:HALF_W];
   assign bus.oprnd    = word_p1[HALF_W-1:0];
   assign bus.valid    = (state_q == HOLD);

endmodule : rom_fetch_ctrl
